ft2232_rx_deframer: RTL and testbench

FT2232_RX_DEFRAMER -- requirements
Module: ft2232_rx_deframer

---
 rtl/ft2232_rx_deframer.sv | 184 ++++++++++++++++++
 tb/tb_ft2232_rx_deframer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft2232_rx_deframer.sv
// ---------------------------------------------------------------------------
// ft2232_rx_deframer
//
// Pulls bytes from the FT2232 IN FIFO (one-cycle read latency), hunts for
// SYNC_BYTE, reads a LEN byte (1..255) and forwards LEN payload bytes
// through a single-entry valid/ready output register tagged with sof/eof.
// Frames with LEN=0 are rejected. Rejections are counted in a saturating
// 8-bit counter.
//
// Optional feature: define FT_RX_CHECKSUM_EN to expect a trailing CHK byte.
// With the checksum enabled, LEN + payload + CHK must sum to 8'h00 modulo 256
// for the frame to be accepted.
//
// Ports
//   clk_i               clock, shared with the IN FIFO read side
//   reset_i             asynchronous active-high reset
//   rd_in_fifo_en_o     IN FIFO read enable
//   rd_in_fifo_data_i   IN FIFO read data, valid the cycle after a read
//   rd_in_fifo_empty_i  IN FIFO empty flag
//   payload_valid_o     payload byte available
//   payload_data_o      payload byte
//   payload_sof_o       first payload byte of a frame
//   payload_eof_o       last payload byte of a frame
//   payload_ready_i     consumer accepts the byte
//   frame_ok_o          one-cycle pulse: frame completed and valid
//   frame_err_o         one-cycle pulse: frame rejected
//   err_count_o         saturating count of rejected frames
// ---------------------------------------------------------------------------
module ft2232_rx_deframer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk_i,
    input  logic       reset_i,
    output logic       rd_in_fifo_en_o,
    input  logic [7:0] rd_in_fifo_data_i,
    input  logic       rd_in_fifo_empty_i,
    output logic       payload_valid_o,
    output logic [7:0] payload_data_o,
    output logic       payload_sof_o,
    output logic       payload_eof_o,
    input  logic       payload_ready_i,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [7:0] err_count_o
);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD
`ifdef FT_RX_CHECKSUM_EN
        , ST_CHK
`endif
    } state_t;

    state_t     state_q, state_d;
    logic       rd_pending_q;     // a read was issued last cycle; data arrives now
    logic [7:0] remain_q, remain_d;
    logic       first_q, first_d; // next payload byte is the first of the frame
    logic       load_out;
    logic       err_d;
    logic       xfer;
    logic [7:0] rx_byte;

`ifdef FT_RX_CHECKSUM_EN
    logic [7:0] acc_q, acc_d;
    logic [7:0] chk_sum;
    logic       ok_d, frame_ok_q;
`endif

    assign rx_byte = rd_in_fifo_data_i;
    assign xfer    = payload_valid_o & payload_ready_i;

    // Only one read in flight, and only when the captured byte has a free
    // slot: the output register is either empty or draining this cycle.
    // Since a capture is the only thing that fills the register, the slot is
    // guaranteed free when the byte lands, so back-pressure never drops data.
    assign rd_in_fifo_en_o = ~reset_i & ~rd_in_fifo_empty_i & ~rd_pending_q
                           & (~payload_valid_o | payload_ready_i);

`ifdef FT_RX_CHECKSUM_EN
    assign chk_sum    = acc_q + rx_byte;
    assign frame_ok_o = frame_ok_q;
`else
    // Without a CHK byte the frame completes when its eof byte is accepted.
    assign frame_ok_o = xfer & payload_eof_o;
`endif

    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        first_d  = first_q;
        load_out = 1'b0;
        err_d    = 1'b0;
`ifdef FT_RX_CHECKSUM_EN
        ok_d     = 1'b0;
        acc_d    = (state_q == ST_HUNT) ? 8'h00 : acc_q;
`endif
        if (rd_pending_q) begin
            case (state_q)
                ST_HUNT: begin
                    if (rx_byte == SYNC_BYTE) state_d = ST_LEN;
                end
                ST_LEN: begin
                    if (rx_byte == 8'h00) begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                    end else begin
                        remain_d = rx_byte;
                        first_d  = 1'b1;
                        state_d  = ST_PAYLOAD;
`ifdef FT_RX_CHECKSUM_EN
                        acc_d    = acc_q + rx_byte;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    load_out = 1'b1;
                    first_d  = 1'b0;
                    remain_d = remain_q - 8'd1;
`ifdef FT_RX_CHECKSUM_EN
                    acc_d    = acc_q + rx_byte;
                    if (remain_q == 8'd1) state_d = ST_CHK;
`else
                    if (remain_q == 8'd1) state_d = ST_HUNT;
`endif
                end
`ifdef FT_RX_CHECKSUM_EN
                ST_CHK: begin
                    if (chk_sum == 8'h00) ok_d = 1'b1;
                    else                  err_d = 1'b1;
                    state_d = ST_HUNT;
                end
`endif
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= ST_HUNT;
            rd_pending_q    <= 1'b0;
            remain_q        <= 8'h00;
            first_q         <= 1'b0;
            payload_valid_o <= 1'b0;
            payload_data_o  <= 8'h00;
            payload_sof_o   <= 1'b0;
            payload_eof_o   <= 1'b0;
            frame_err_o     <= 1'b0;
            err_count_o     <= 8'h00;
`ifdef FT_RX_CHECKSUM_EN
            acc_q           <= 8'h00;
            frame_ok_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd_in_fifo_en_o;
            remain_q     <= remain_d;
            first_q      <= first_d;
            frame_err_o  <= err_d;
            if (err_d && (err_count_o != 8'hFF)) err_count_o <= err_count_o + 8'd1;
`ifdef FT_RX_CHECKSUM_EN
            acc_q      <= acc_d;
            frame_ok_q <= ok_d;
`endif
            if (load_out) begin
                payload_valid_o <= 1'b1;
                payload_data_o  <= rx_byte;
                payload_sof_o   <= first_q;
                payload_eof_o   <= (remain_q == 8'd1);
            end else if (xfer) begin
                payload_valid_o <= 1'b0;
                payload_sof_o   <= 1'b0;
                payload_eof_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ft2232_rx_deframer.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for ft2232_rx_deframer. Stimulus tasks build byte streams
// from frame descriptions, feed a queue-based IN FIFO model and push the
// expected payload bytes and frame events; a negedge monitor pops and
// compares whenever the DUT presents a transfer or a frame pulse.
// ---------------------------------------------------------------------------
module tb_ft2232_rx_deframer;

    localparam logic [7:0] SYNC = 8'hA5;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } pl_t;

    typedef struct packed {
        logic       is_ok;
        logic [7:0] cnt;
    } ev_t;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       rd_in_fifo_en_o;
    logic [7:0] rd_in_fifo_data_i = 8'h00;
    logic       rd_in_fifo_empty_i = 1'b1;
    logic       payload_valid_o;
    logic [7:0] payload_data_o;
    logic       payload_sof_o;
    logic       payload_eof_o;
    logic       payload_ready_i = 1'b0;
    logic       frame_ok_o;
    logic       frame_err_o;
    logic [7:0] err_count_o;

    ft2232_rx_deframer #(.SYNC_BYTE(SYNC)) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .rd_in_fifo_en_o    (rd_in_fifo_en_o),
        .rd_in_fifo_data_i  (rd_in_fifo_data_i),
        .rd_in_fifo_empty_i (rd_in_fifo_empty_i),
        .payload_valid_o    (payload_valid_o),
        .payload_data_o     (payload_data_o),
        .payload_sof_o      (payload_sof_o),
        .payload_eof_o      (payload_eof_o),
        .payload_ready_i    (payload_ready_i),
        .frame_ok_o         (frame_ok_o),
        .frame_err_o        (frame_err_o),
        .err_count_o        (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_vec  = 0;
    int         n_fail = 0;
    int         n_xfer = 0;
    int         n_reads = 0;
    int         cyc = 0;
    int         err_model = 0;
    int         ready_mode = 0;    // 0: always ready, 1: random, 2: stalled
    bit         measure = 1'b0;
    int         meas_len = 0;
    int         sof_cyc = 0;
    bit         held_valid = 1'b0;
    pl_t        held;

    logic [7:0] fifo_q[$];
    logic [7:0] pl_buf[$];
    pl_t        exp_q[$];
    ev_t        ev_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // IN FIFO model: a read sampled at the edge presents its byte for the
    // whole following cycle; otherwise the data bus carries junk.
    always @(posedge clk_i) begin
        logic take;
        take = rd_in_fifo_en_o && !rd_in_fifo_empty_i;
        #1;
        if (take && fifo_q.size() > 0) begin
            rd_in_fifo_data_i = fifo_q.pop_front();
            n_reads++;
        end else begin
            rd_in_fifo_data_i = 8'($urandom);
        end
        rd_in_fifo_empty_i = (fifo_q.size() == 0);
    end

    always @(posedge clk_i) begin
        #1;
        case (ready_mode)
            0:       payload_ready_i = 1'b1;
            1:       payload_ready_i = ($urandom_range(0, 3) != 0);
            default: payload_ready_i = 1'b0;
        endcase
    end

    // Monitor / scoreboard.
    always @(negedge clk_i) begin
        pl_t got;
        pl_t exp;
        ev_t ev;
        cyc++;
        if (!reset_i) begin
            got = '{data: payload_data_o, sof: payload_sof_o, eof: payload_eof_o};
            if (payload_valid_o && held_valid)
                check("held_stable", 32'(got), 32'(held));
            if (payload_valid_o && payload_ready_i) begin
                check("payload_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    check("payload_data", 32'(got.data), 32'(exp.data));
                    check("payload_sof_eof", {30'd0, got.sof, got.eof}, {30'd0, exp.sof, exp.eof});
                end
                n_xfer++;
                if (got.sof) sof_cyc = cyc;
                if (got.eof && measure) begin
                    check("throughput_cycles", 32'(cyc - sof_cyc), 32'(2 * (meas_len - 1)));
                    measure = 1'b0;
                end
                held_valid = 1'b0;
            end else if (payload_valid_o) begin
                check("no_read_while_stalled", 32'(rd_in_fifo_en_o), 32'd0);
                held = got;
                held_valid = 1'b1;
            end else begin
                held_valid = 1'b0;
            end
            if (frame_ok_o || frame_err_o) begin
                check("ok_err_exclusive", 32'(frame_ok_o && frame_err_o), 32'd0);
                check("event_expected", 32'(ev_q.size() > 0), 32'd1);
                if (ev_q.size() > 0) begin
                    ev = ev_q.pop_front();
                    check("event_kind_ok", 32'(frame_ok_o), 32'(ev.is_ok));
                    check("err_count", 32'(err_count_o), 32'(ev.cnt));
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        rd_in_fifo_empty_i = 1'b0;
    endtask

    // Reference model: one frame description -> bytes on the wire plus the
    // payload and event expectations. chk_force < 0 means a correct CHK.
    task automatic push_frame(input int len, input int chk_force);
        int  sum;
        ev_t ev;
        pl_t p;
        push_byte(SYNC);
        push_byte(8'(len));
        sum = len;
        if (len == 0) begin
            err_model = (err_model >= 255) ? 255 : err_model + 1;
            ev.is_ok = 1'b0;
            ev.cnt   = 8'(err_model);
            ev_q.push_back(ev);
            return;
        end
        for (int i = 0; i < len; i++) begin
            push_byte(pl_buf[i]);
            sum += int'(pl_buf[i]);
            p.data = pl_buf[i];
            p.sof  = (i == 0);
            p.eof  = (i == len - 1);
            exp_q.push_back(p);
        end
`ifdef FT_RX_CHECKSUM_EN
        begin
            int chk;
            chk = (chk_force < 0) ? (256 - sum % 256) % 256 : chk_force;
            push_byte(8'(chk));
            if ((sum + chk) % 256 == 0) begin
                ev.is_ok = 1'b1;
            end else begin
                err_model = (err_model >= 255) ? 255 : err_model + 1;
                ev.is_ok = 1'b0;
            end
        end
`else
        ev.is_ok = 1'b1;
        if (chk_force > 255) ev.is_ok = 1'b0;  // never true; keeps the argument used
`endif
        ev.cnt = 8'(err_model);
        ev_q.push_back(ev);
    endtask

    task automatic rand_payload(input int len);
        pl_buf.delete();
        for (int i = 0; i < len; i++) pl_buf.push_back(8'($urandom));
    endtask

    task automatic drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk_i); #1;
            done = (exp_q.size() == 0) && (ev_q.size() == 0) && (fifo_q.size() == 0)
                   && !payload_valid_o;
        end
        repeat (4) @(negedge clk_i);
        #1;
        check(name, 32'(done && ev_q.size() == 0 && exp_q.size() == 0), 32'd1);
    endtask

    task automatic wait_xfer(input int target, input int budget);
        for (int k = 0; k < budget && n_xfer < target; k++) begin
            @(negedge clk_i); #1;
        end
        check("xfer_reached", 32'(n_xfer >= target), 32'd1);
    endtask

    initial begin
        // Reset state, with a byte already waiting in the FIFO.
        push_byte(8'h3C);
        #12;
        check("rst_rd_en", 32'(rd_in_fifo_en_o), 32'd0);
        check("rst_outputs", {23'd0, payload_valid_o, payload_sof_o, payload_eof_o,
                              frame_ok_o, frame_err_o, 4'd0},
              32'd0);
        check("rst_data", 32'(payload_data_o), 32'h00);
        check("rst_err_count", 32'(err_count_o), 32'h00);
        @(posedge clk_i); #2;
        reset_i = 1'b0;

        // Basic three-byte frame, consumer always ready.
        ready_mode = 0;
        pl_buf = '{8'h11, 8'h22, 8'h33};
        push_frame(3, -1);
        drain("drain_basic", 200);

        // Garbage before sync, single-byte frame.
        push_byte(8'h00);
        push_byte(8'hFF);
        pl_buf = '{8'h5A};
        push_frame(1, -1);
        drain("drain_single", 200);

        // LEN=0 rejection, then a good frame.
        push_frame(0, -1);
        pl_buf = '{8'hC3, 8'h3C};
        push_frame(2, -1);
        drain("drain_len0", 200);
        check("err_count_after_len0", 32'(err_count_o), 32'd1);

`ifdef FT_RX_CHECKSUM_EN
        // Bad checksum: payload still delivered, frame rejected.
        pl_buf = '{8'h10, 8'h20};
        push_frame(2, 0);
        drain("drain_badchk", 200);
        check("err_count_after_badchk", 32'(err_count_o), 32'd2);
`endif

        // Consumer stalls for ten cycles in the middle of a frame.
        rand_payload(6);
        push_frame(6, -1);
        wait_xfer(n_xfer + 2, 200);
        ready_mode = 2;
        begin
            int r0;
            repeat (3) @(negedge clk_i);
            #1;
            r0 = n_reads;
            check("stall_valid_held", 32'(payload_valid_o), 32'd1);
            repeat (7) @(negedge clk_i);
            #1;
            check("stall_no_reads", 32'(n_reads), 32'(r0));
            check("stall_valid_end", 32'(payload_valid_o), 32'd1);
        end
        ready_mode = 0;
        drain("drain_stall", 300);

        // Reset two payload bytes into a LEN=5 frame.
        rand_payload(5);
        push_frame(5, -1);
        wait_xfer(n_xfer + 2, 200);
        @(posedge clk_i); #2;
        reset_i = 1'b1;
        fifo_q.delete();
        rd_in_fifo_empty_i = 1'b1;
        exp_q.delete();
        ev_q.delete();
        err_model  = 0;
        held_valid = 1'b0;
        #1;
        check("midrst_valid", 32'(payload_valid_o), 32'd0);
        check("midrst_flags", {28'd0, payload_sof_o, payload_eof_o, frame_ok_o, frame_err_o}, 32'd0);
        check("midrst_err_count", 32'(err_count_o), 32'd0);
        check("midrst_rd_en", 32'(rd_in_fifo_en_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        pl_buf = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        push_frame(4, -1);
        drain("drain_after_reset", 200);

        // Longest frame with the consumer always ready: one byte per two cycles.
        rand_payload(255);
        meas_len = 255;
        measure  = 1'b1;
        push_frame(255, -1);
        drain("drain_throughput", 1200);
        check("throughput_measured", 32'(measure), 32'd0);

        // Random frames, random garbage, random back-pressure.
        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int r;
            int len;
            int chk;
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                push_byte(b);
            end
            r = $urandom_range(0, 19);
            if (r == 0)      len = 0;
            else if (r == 1) len = $urandom_range(9, 60);
            else             len = $urandom_range(1, 8);
            chk = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : -1;
            rand_payload(len);
            push_frame(len, chk);
            repeat ($urandom_range(0, 12)) @(negedge clk_i);
        end
        ready_mode = 0;
        drain("drain_random", 4000);

        // Error counter saturation.
        for (int f = 0; f < 260; f++) push_frame(0, -1);
        drain("drain_saturate", 3000);
        check("err_count_saturated", 32'(err_count_o), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
